weight_preload_buffer: RTL and testbench
========================================

Name: weight_preload_buffer

Overview:
Upstream neighbour of the weight BRAM write controller. Accepts the weight stream on a narrow AXI-Stream slave and assembles beats into 5*MAC_NUM-bit weight words. Completed words go into a small first-word-fall-through FIFO, which the BRAM controller drains one word per read pulse. It reports FIFO occupancy and a "word available" flag that the write FSM waits on.

Parameters:
MAC_NUM, 256, MAC lanes; word width WORD_W = 5*MAC_NUM bits.
AXIS_DATA_WIDTH, 64, s_axis beat width; WORD_W must be an integer multiple of it; BEATS = WORD_W/AXIS_DATA_WIDTH (20 at defaults).
AXIS_PRELOAD_FIFO_DEPTH, 4, FIFO depth in words.
bit_num, 2, count port is bit_num+1 bits; DEPTH <= 2^(bit_num+1)-1.

Ports:
clk  in  1  clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
s_axis_tdata  in  AXIS_DATA_WIDTH  weight beat.
s_axis_tvalid  in  1  beat valid.
s_axis_tlast  in  1  final beat of the layer's weight stream.
s_axis_tready  out  1  beat accepted when tvalid&&tready.
read_axis_preload_fifo  in  1  pop request from the BRAM controller.
layer_finish  in  1  synchronous flush.
weight_from_preload  out  5*MAC_NUM  FIFO head word, first-word fall-through.
axis_fifo_cnt  out  bit_num+1  words held, 0..DEPTH.
wait_input_from_preload  out  1  high when axis_fifo_cnt != 0.
stream_done  out  1  one-cycle pulse when the word containing tlast is pushed.
pop_underflow  out  1  sticky flag: pop requested while empty.

Behaviour:
- Reset (rst=1) takes priority over everything. Reset values:
  - FIFO emptied; cnt=0; wait=0; weight_from_preload=0.
  - Assembler cleared; beat_cnt=0; state=A_FILL; tready=1.
  - stream_done=0; pop_underflow=0.
- layer_finish has the same effect as rst. It overrides a same-cycle push, pop or beat acceptance, and it clears all memory entries so the head reads 0.
- Assembler FSM:
  - A_FILL: tready=1. On an accepted beat, the beat is written to slot beat_cnt, with beat k at bits [(k+1)*DW-1 : k*DW].
    - If beat_cnt==BEATS-1 or tlast=1: go to A_PUSH; latch last_flag=tlast.
    - Otherwise beat_cnt increments.
  - A_PUSH: tready=0. A push occurs when cnt<DEPTH, or when cnt==DEPTH and a valid pop occurs the same cycle.
    - On push: word enters the FIFO tail; assembly register cleared to 0; beat_cnt=0; return to A_FILL.
    - stream_done=1 on the cycle after the push edge if last_flag was set.
    - If no push is possible, stay in A_PUSH.
- Early tlast: unwritten slots of the word remain 0 (zero-padded), because the register is cleared on every push.
- Latency:
  - Last beat accepted at edge N → A_PUSH after N → push at edge N+1 → cnt and head valid after N+1.
  - Throughput is BEATS+1 cycles per word.
- FIFO (FWFT):
  - Pop is valid when read_axis_preload_fifo=1 and cnt!=0. The head is valid during the pop cycle; the consumer captures it at that edge and the next entry appears after it.
  - Pop while empty: ignored; cnt unchanged; pop_underflow set to 1 and held until rst or layer_finish.
  - Push and pop in the same cycle: cnt unchanged. When empty, only the push takes effect (the pop is an underflow).
  - Pointers are modulo DEPTH and wrap cleanly for non-power-of-2 depth. cnt never exceeds DEPTH; overflow is structurally impossible.
- All outputs are registered or driven from registers only. No combinational path from read_axis_preload_fifo or tvalid to s_axis_tready.

Decomposition:
- Package weight_preload_pkg holds:
  - WORD_W and BEATS derivation functions;
  - clogb2;
  - assembler state encodings A_FILL=1'b0, A_PUSH=1'b1.
- One sub-module, weight_preload_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH; ports push, pop, din, dout, count, underflow, flush.
- The assembler FSM lives in the top level.

Test Plan:
1. Assert rst 2 cycles, then release → tready=1, cnt=0, wait=0, weight_from_preload=0, pop_underflow=0.
2. Send 20 beats with beat k = 64'h1000+k and no tlast → one cycle after the last handshake: cnt=1, wait=1, weight[63:0]=64'h1000, weight[1279:1216]=64'h1013; tready low for exactly 1 cycle.
3. Send 5 full words with no pops → cnt=4, tready=0, FSM held in A_PUSH. Pulse read once → that edge pushes word 5, cnt stays 4, head = word 2, tready=1 next cycle.
4. Send 6 beats (0xA0..0xA5) with tlast on the 6th → word pushed: bits [383:0] hold the 6 beats, bits [1279:384]=0; stream_done pulses once.
5. Pulse read at cnt=0 → cnt stays 0, pop_underflow=1 and remains high. Then push a word → cnt=1, pop_underflow still 1.
6. With cnt=2 and beat_cnt=7, assert layer_finish concurrently with tvalid and read → next cycle cnt=0, beat_cnt=0, pop_underflow=0, tready=1; the flush-cycle beat is discarded.

Source files
------------

// File: rtl/weight_preload_pkg.sv
// Shared sizing helpers and assembler state encoding for the weight preload buffer.
package weight_preload_pkg;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int calc_word_w(input int mac_num);
    return 5 * mac_num;
  endfunction

  function automatic int calc_beats(input int word_w, input int data_w);
    return word_w / data_w;
  endfunction

  typedef enum logic {
    A_FILL = 1'b0,
    A_PUSH = 1'b1
  } asm_state_e;

endpackage

// File: rtl/weight_preload_fifo.sv
// Small first-word-fall-through FIFO; flush clears every entry so the head reads zero.
module weight_preload_fifo
  import weight_preload_pkg::*;
#(
  parameter int WIDTH = 1280,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  localparam int PTR_W = clogb2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             underflow_reg;
  logic             pop_ok;
  logic             push_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok  = pop && (count_reg != '0);
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign push_ok = push && ((count_reg < CNT_W'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (push_ok) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      underflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
      else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
      if (pop && (count_reg == '0)) underflow_reg <= 1'b1;
    end
  end

  assign dout      = mem_reg[rd_ptr_reg];
  assign count     = count_reg;
  assign underflow = underflow_reg;

endmodule

// File: rtl/weight_preload_buffer.sv
// Packs narrow AXI-Stream weight beats into MAC-wide words and queues them for the BRAM writer.
module weight_preload_buffer
  import weight_preload_pkg::*;
#(
  parameter int MAC_NUM                 = 256,
  parameter int AXIS_DATA_WIDTH         = 64,
  parameter int AXIS_PRELOAD_FIFO_DEPTH = 4,
  parameter int bit_num                 = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  input  logic                       read_axis_preload_fifo,
  input  logic                       layer_finish,
  output logic [5*MAC_NUM-1:0]       weight_from_preload,
  output logic [bit_num:0]           axis_fifo_cnt,
  output logic                       wait_input_from_preload,
  output logic                       stream_done,
  output logic                       pop_underflow
);

  localparam int WORD_W = calc_word_w(MAC_NUM);
  localparam int DW     = AXIS_DATA_WIDTH;
  localparam int BEATS  = calc_beats(WORD_W, DW);
  localparam int BCNT_W = clogb2(BEATS);
  localparam int CNT_W  = bit_num + 1;
  localparam int DEPTH  = AXIS_PRELOAD_FIFO_DEPTH;

  asm_state_e        state_reg;
  logic [BCNT_W-1:0] beat_cnt_reg;
  logic              last_flag_reg;
  logic              stream_done_reg;
  logic [WORD_W-1:0] asm_reg;
  logic [BEATS-1:0]  slot_we;
  logic              beat_fire;
  logic              push_fire;
  logic [CNT_W-1:0]  fifo_cnt;

  assign beat_fire = s_axis_tvalid && (state_reg == A_FILL);
  assign push_fire = (state_reg == A_PUSH) &&
                     ((fifo_cnt < CNT_W'(DEPTH)) ||
                      ((fifo_cnt == CNT_W'(DEPTH)) && read_axis_preload_fifo));

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot_we
      assign slot_we[gi] = beat_fire && (beat_cnt_reg == BCNT_W'(gi));
    end
  endgenerate

  // Clearing on every push is what zero-pads a word cut short by tlast.
  always_ff @(posedge clk) begin
    if (rst || layer_finish || push_fire) begin
      asm_reg <= '0;
    end else begin
      for (int k = 0; k < BEATS; k++) begin
        if (slot_we[k]) asm_reg[k*DW +: DW] <= s_axis_tdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || layer_finish) begin
      state_reg       <= A_FILL;
      beat_cnt_reg    <= '0;
      last_flag_reg   <= 1'b0;
      stream_done_reg <= 1'b0;
    end else begin
      stream_done_reg <= push_fire && last_flag_reg;
      case (state_reg)
        A_FILL: begin
          if (beat_fire) begin
            if ((beat_cnt_reg == BCNT_W'(BEATS - 1)) || s_axis_tlast) begin
              state_reg     <= A_PUSH;
              last_flag_reg <= s_axis_tlast;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        A_PUSH: begin
          if (push_fire) begin
            state_reg    <= A_FILL;
            beat_cnt_reg <= '0;
          end
        end
        default: state_reg <= A_FILL;
      endcase
    end
  end

  weight_preload_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (layer_finish),
    .push     (push_fire),
    .pop      (read_axis_preload_fifo),
    .din      (asm_reg),
    .dout     (weight_from_preload),
    .count    (fifo_cnt),
    .underflow(pop_underflow)
  );

  assign s_axis_tready           = (state_reg == A_FILL);
  assign axis_fifo_cnt           = fifo_cnt;
  assign wait_input_from_preload = (fifo_cnt != '0);
  assign stream_done             = stream_done_reg;

endmodule

// File: tb/tb_weight_preload_buffer.sv
// Scoreboard bench: expected words are queued as beats are driven and compared at each pop.
module tb_weight_preload_buffer;

  localparam int MAC_NUM = 256;
  localparam int DW      = 64;
  localparam int DEPTH   = 4;
  localparam int BIT_NUM = 2;
  localparam int WORD_W  = 5 * MAC_NUM;
  localparam int BEATS   = WORD_W / DW;

  typedef logic [WORD_W-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic              read_axis_preload_fifo;
  logic              layer_finish;
  logic [WORD_W-1:0] weight_from_preload;
  logic [BIT_NUM:0]  axis_fifo_cnt;
  logic              wait_input_from_preload;
  logic              stream_done;
  logic              pop_underflow;

  int    checks = 0;
  int    errors = 0;
  word_t sb_q[$];

  always #5 clk = ~clk;

  weight_preload_buffer #(
    .MAC_NUM(MAC_NUM),
    .AXIS_DATA_WIDTH(DW),
    .AXIS_PRELOAD_FIFO_DEPTH(DEPTH),
    .bit_num(BIT_NUM)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_tdata           (s_axis_tdata),
    .s_axis_tvalid          (s_axis_tvalid),
    .s_axis_tlast           (s_axis_tlast),
    .s_axis_tready          (s_axis_tready),
    .read_axis_preload_fifo (read_axis_preload_fifo),
    .layer_finish           (layer_finish),
    .weight_from_preload    (weight_from_preload),
    .axis_fifo_cnt          (axis_fifo_cnt),
    .wait_input_from_preload(wait_input_from_preload),
    .stream_done            (stream_done),
    .pop_underflow          (pop_underflow)
  );

  task automatic chk(input string tag, input word_t got, input word_t exp);
    int k;
    checks++;
    if (got !== exp) begin
      errors++;
      k = 0;
      for (int i = BEATS - 1; i >= 0; i--) begin
        if (got[i*DW +: DW] !== exp[i*DW +: DW]) k = i;
      end
      $display("FAIL %s beat %0d got=%h exp=%h", tag, k, got[k*DW +: DW], exp[k*DW +: DW]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] data, input logic last);
    int n;
    n = 0;
    while (!s_axis_tready && n < 200) begin
      step();
      n++;
    end
    if (!s_axis_tready) begin
      chk("tready_timeout", word_t'(s_axis_tready), word_t'(1));
      return;
    end
    s_axis_tdata  = data;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_word(input int n, input bit last, input bit rnd, input logic [DW-1:0] base,
                           input bit expect_push);
    word_t         exp;
    logic [DW-1:0] d;
    exp = '0;
    for (int k = 0; k < n; k++) begin
      d = rnd ? {$urandom, $urandom} : base + DW'(k);
      exp[k*DW +: DW] = d;
      send_beat(d, last && (k == n - 1));
    end
    if (expect_push) sb_q.push_back(exp);
  endtask

  task automatic pop_word(input string tag);
    word_t exp;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, word_t'(1), word_t'(0));
      return;
    end
    exp = sb_q.pop_front();
    read_axis_preload_fifo = 1'b1;
    chk(tag, weight_from_preload, exp);
    step();
    read_axis_preload_fifo = 1'b0;
    $display("pop %s head_lo=%h cnt_after=%0d", tag, exp[DW-1:0], axis_fifo_cnt);
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    read_axis_preload_fifo = 1'b0;
    layer_finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_tready", word_t'(s_axis_tready), word_t'(1));
    chk("rst_cnt", word_t'(axis_fifo_cnt), word_t'(0));
    chk("rst_wait", word_t'(wait_input_from_preload), word_t'(0));
    chk("rst_head", weight_from_preload, word_t'(0));
    chk("rst_uflow", word_t'(pop_underflow), word_t'(0));
    chk("rst_done", word_t'(stream_done), word_t'(0));

    // One full word, ramp pattern, then check push latency
    send_word(BEATS, 1'b0, 1'b0, 64'h1000, 1'b1);
    chk("t2_tready_low", word_t'(s_axis_tready), word_t'(0));
    chk("t2_cnt_pre", word_t'(axis_fifo_cnt), word_t'(0));
    step();
    chk("t2_cnt", word_t'(axis_fifo_cnt), word_t'(1));
    chk("t2_wait", word_t'(wait_input_from_preload), word_t'(1));
    chk("t2_lo", word_t'(weight_from_preload[63:0]), word_t'(64'h1000));
    chk("t2_hi", word_t'(weight_from_preload[1279:1216]), word_t'(64'h1013));
    chk("t2_tready_back", word_t'(s_axis_tready), word_t'(1));
    chk("t2_no_done", word_t'(stream_done), word_t'(0));
    pop_word("t2_pop");
    chk("t2_cnt_drained", word_t'(axis_fifo_cnt), word_t'(0));

    // Fill the FIFO and stall the assembler on the fifth word
    for (int w = 0; w < 5; w++) send_word(BEATS, 1'b0, 1'b1, '0, 1'b1);
    repeat (3) step();
    chk("t3_cnt_full", word_t'(axis_fifo_cnt), word_t'(DEPTH));
    chk("t3_tready_stall", word_t'(s_axis_tready), word_t'(0));
    pop_word("t3_pop_full");
    chk("t3_cnt_same", word_t'(axis_fifo_cnt), word_t'(DEPTH));
    chk("t3_head_next", weight_from_preload, sb_q[0]);
    chk("t3_tready_back", word_t'(s_axis_tready), word_t'(1));
    for (int w = 0; w < DEPTH; w++) pop_word("t3_drain");
    chk("t3_cnt_empty", word_t'(axis_fifo_cnt), word_t'(0));

    // Short word terminated by tlast is zero-padded and flags stream_done
    send_word(6, 1'b1, 1'b0, 64'hA0, 1'b1);
    chk("t4_done_pre", word_t'(stream_done), word_t'(0));
    step();
    chk("t4_done", word_t'(stream_done), word_t'(1));
    chk("t4_cnt", word_t'(axis_fifo_cnt), word_t'(1));
    chk("t4_pad", word_t'(weight_from_preload[1279:384]), word_t'(0));
    step();
    chk("t4_done_clear", word_t'(stream_done), word_t'(0));
    pop_word("t4_pop");

    // Pop while empty sets a sticky underflow
    read_axis_preload_fifo = 1'b1;
    step();
    read_axis_preload_fifo = 1'b0;
    chk("t5_cnt", word_t'(axis_fifo_cnt), word_t'(0));
    chk("t5_uflow", word_t'(pop_underflow), word_t'(1));
    step();
    chk("t5_uflow_hold", word_t'(pop_underflow), word_t'(1));
    send_word(BEATS, 1'b0, 1'b1, '0, 1'b1);
    step();
    chk("t5_cnt_push", word_t'(axis_fifo_cnt), word_t'(1));
    chk("t5_uflow_sticky", word_t'(pop_underflow), word_t'(1));

    // layer_finish mid-word overrides a concurrent beat and pop
    send_word(BEATS, 1'b0, 1'b1, '0, 1'b1);
    step();
    chk("t6_cnt_two", word_t'(axis_fifo_cnt), word_t'(2));
    send_word(7, 1'b0, 1'b1, '0, 1'b0);
    layer_finish = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 64'hDEAD_BEEF_0BAD_F00D;
    read_axis_preload_fifo = 1'b1;
    step();
    layer_finish = 1'b0;
    s_axis_tvalid = 1'b0;
    read_axis_preload_fifo = 1'b0;
    sb_q.delete();
    chk("t6_cnt", word_t'(axis_fifo_cnt), word_t'(0));
    chk("t6_wait", word_t'(wait_input_from_preload), word_t'(0));
    chk("t6_uflow", word_t'(pop_underflow), word_t'(0));
    chk("t6_tready", word_t'(s_axis_tready), word_t'(1));
    chk("t6_head", weight_from_preload, word_t'(0));
    send_word(BEATS, 1'b0, 1'b0, 64'h5000, 1'b1);
    step();
    chk("t6_cnt_after", word_t'(axis_fifo_cnt), word_t'(1));
    pop_word("t6_realign");
    chk("t6_sb_empty", word_t'(sb_q.size()), word_t'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
